rob_wb_arbiter: RTL

- Shares the ROB's single writeback port (entry index, valid, result, new PC, branch-taken) between NUM_REQ functional-unit requesters, e.g. ALU, MUL and LSU.
- Arbitration is round-robin with a valid/ready handshake per requester.
- The winner's payload is registered and drives the ROB writeback inputs one cycle after grant.
- Sits between the execute units and the rob module in the wb stage.

---
 rtl/rob_wb_arbiter_if.sv | 41 ++++
 rtl/rob_wb_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/rob_wb_arbiter_if.sv
// rob_wb_arbiter_if: bundle between the execute-unit requesters and the ROB
// writeback arbiter. Signal suffixes are from the arbiter's point of view.
//   flush_i             pipeline flush
//   req_valid_i/ready_o per-requester handshake (ready one-hot or zero)
//   req_*_i             packed per-requester payload, requester k in slice k
//   wb_*_o              registered writeback towards the ROB
//   wb_src_o            requester whose payload sits on wb_* (debug/perf)
// Modports: master = requester/ROB side, slave = arbiter.
interface rob_wb_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int ROB_IDX_W = 4,
  parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic                           flush_i;
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_i;
  logic [NUM_REQ*32-1:0]          req_result_i;
  logic [NUM_REQ*32-1:0]          req_new_pc_i;
  logic [NUM_REQ-1:0]             req_branch_taken_i;
  logic                           wb_valid_o;
  logic [ROB_IDX_W-1:0]           wb_rob_idx_o;
  logic [31:0]                    wb_result_o;
  logic [31:0]                    wb_new_pc_o;
  logic                           wb_branch_taken_o;
  logic [PTR_W-1:0]               wb_src_o;

  modport master (
    output flush_i, req_valid_i, req_rob_idx_i, req_result_i, req_new_pc_i,
           req_branch_taken_i,
    input  req_ready_o, wb_valid_o, wb_rob_idx_o, wb_result_o, wb_new_pc_o,
           wb_branch_taken_o, wb_src_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_rob_idx_i, req_result_i, req_new_pc_i,
           req_branch_taken_i,
    output req_ready_o, wb_valid_o, wb_rob_idx_o, wb_result_o, wb_new_pc_o,
           wb_branch_taken_o, wb_src_o
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: round-robin arbiter sharing the ROB's single writeback port
// between NUM_REQ functional units. The grant is combinational; the winner's
// payload is registered and presented on wb_* one cycle later.
//   clk_i  clock (rising edge)
//   rst_i  synchronous active-high reset
//   bus    rob_wb_arbiter_if.slave: flush, request handshake/payload, wb_* out
module rob_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ROB_IDX_W = 4,
  parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rob_wb_arbiter_if.slave  bus
);
  localparam int unsigned N = NUM_REQ;

  logic [NUM_REQ-1:0]   grant;
  logic                 found;
  int unsigned          ptr_u;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [ROB_IDX_W-1:0] wb_rob_idx_q, wb_rob_idx_d;
  logic [31:0]          wb_result_q, wb_result_d;
  logic [31:0]          wb_new_pc_q, wb_new_pc_d;
  logic                 wb_branch_taken_q, wb_branch_taken_d;
  logic [PTR_W-1:0]     wb_src_q, wb_src_d;

  // Outer loop walks priority order starting at rr_ptr_q; inner loop maps that
  // slot back to a constant requester index so every select stays static.
  always_comb begin
    grant             = '0;
    found             = 1'b0;
    ptr_u             = 32'(rr_ptr_q);
    rr_ptr_d          = rr_ptr_q;
    wb_valid_d        = 1'b0;
    wb_rob_idx_d      = wb_rob_idx_q;
    wb_result_d       = wb_result_q;
    wb_new_pc_d       = wb_new_pc_q;
    wb_branch_taken_d = wb_branch_taken_q;
    wb_src_d          = wb_src_q;
    if (!rst_i && !bus.flush_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (!found && (k == (ptr_u + i) % N) && bus.req_valid_i[k]) begin
            found             = 1'b1;
            grant[k]          = 1'b1;
            wb_valid_d        = 1'b1;
            wb_rob_idx_d      = bus.req_rob_idx_i[k*ROB_IDX_W +: ROB_IDX_W];
            wb_result_d       = bus.req_result_i[k*32 +: 32];
            wb_new_pc_d       = bus.req_new_pc_i[k*32 +: 32];
            wb_branch_taken_d = bus.req_branch_taken_i[k];
            wb_src_d          = PTR_W'(k);
            rr_ptr_d          = (k == N - 1) ? '0 : PTR_W'(k + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q          <= '0;
      wb_valid_q        <= 1'b0;
      wb_rob_idx_q      <= '0;
      wb_result_q       <= '0;
      wb_new_pc_q       <= '0;
      wb_branch_taken_q <= 1'b0;
      wb_src_q          <= '0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      wb_valid_q        <= wb_valid_d;
      wb_rob_idx_q      <= wb_rob_idx_d;
      wb_result_q       <= wb_result_d;
      wb_new_pc_q       <= wb_new_pc_d;
      wb_branch_taken_q <= wb_branch_taken_d;
      wb_src_q          <= wb_src_d;
    end
  end

  assign bus.req_ready_o       = grant;
  assign bus.wb_valid_o        = wb_valid_q;
  assign bus.wb_rob_idx_o      = wb_rob_idx_q;
  assign bus.wb_result_o       = wb_result_q;
  assign bus.wb_new_pc_o       = wb_new_pc_q;
  assign bus.wb_branch_taken_o = wb_branch_taken_q;
  assign bus.wb_src_o          = wb_src_q;
endmodule
